mc_ctrl_fsm: RTL and testbench
==============================

// Module: mc_ctrl_fsm
// PURPOSE
//  Multi-cycle control sequencer for the MIPS datapath; replaces the single-cycle opcode decode.
//  Walks each instruction through FETCH/DECODE/EXEC/MEM/WB states, driving datapath enables per cycle.
//  Runs a req/ready handshake to the unified instruction/data memory port.
//  Uses the team's 4-bit aluop encoding and flags illegal opcodes.
// PARAMETERS
//  MEM_TIMEOUT  8'd255  max wait cycles for mem_ready; 0 disables the timeout
// PORTS
//  clk          in   1  system clock, rising edge
//  resetn       in   1  asynchronous reset, active-low
//  op           in   6  instr[31:26], valid from DECODE onward (IR already loaded)
//  zero         in   1  ALU zero flag, sampled in BRANCH
//  mem_ready    in   1  memory completes the access this cycle
//  mem_req      out  1  memory access request
//  mem_we       out  1  write strobe, qualified by mem_req
//  iord         out  1  0 = PC addresses memory, 1 = ALUOut addresses memory
//  irwrite      out  1  load IR
//  pcwrite      out  1  unconditional PC load
//  pcsrc        out  2  00 ALU, 01 ALUOut, 10 jump target, 11 exception vector
//  regwrite     out  1  register file write
//  regdst       out  1  1 = rd, 0 = rt
//  memtoreg     out  1  1 = MDR, 0 = ALUOut
//  alusrca      out  1  0 = PC, 1 = rs
//  alusrcb      out  2  00 rt, 01 const 4, 10 sign-ext imm, 11 imm<<2
//  aluop        out  4  codes: 1000 R, 0100 add, 1011 sub/beq, 0101 addiu, 0110 slti, 0111 sltiu,
//                       0000 andi, 0001 xori, 0010 lui, 0011 ori
//  bus_err      out  1  one-cycle pulse on memory timeout
//  exc_illop    out  1  one-cycle pulse on illegal opcode
//  state        out  4  current state, for debug/trace
// BEHAVIOUR
//  Reset: state=IDLE(0); every output is 0; wait counter is 0.
//  Outputs decode from the state register (Moore), except irwrite/pcwrite in FETCH, which are
//  gated by mem_ready (Mealy).
//  IDLE: all outputs 0 -> FETCH next cycle.
//  FETCH(1): mem_req=1, iord=0, alusrca=0, alusrcb=01, aluop=0100, pcsrc=00.
//    On mem_ready: irwrite=1, pcwrite=1 -> DECODE. Otherwise stay.
//  DECODE(2): alusrca=0, alusrcb=11, aluop=0100 (branch target into ALUOut). Dispatch on op:
//    000000 -> EXEC; 100011/101011 -> MEMADR; 000100 -> BRANCH; 000010 -> JUMP;
//    001000,001001,001010,001011,001100,001101,001110,001111 -> IEXEC; others -> ILLOP.
//  MEMADR(3): alusrca=1, alusrcb=10, aluop=0100 -> MEMRD if lw, MEMWR if sw.
//  MEMRD(4): mem_req=1, iord=1; on mem_ready -> MEMWB.
//  MEMWB(5): regwrite=1, regdst=0, memtoreg=1 -> FETCH.
//  MEMWR(6): mem_req=1, mem_we=1, iord=1; on mem_ready -> FETCH.
//  EXEC(7): alusrca=1, alusrcb=00, aluop=1000 -> RWB.
//  RWB(8): regwrite=1, regdst=1, memtoreg=0 -> FETCH.
//  IEXEC(9): alusrca=1, alusrcb=10, aluop from op (addi 0100, addiu 0101, slti 0110, sltiu 0111,
//    andi 0000, xori 0001, lui 0010, ori 0011) -> IWB.
//  IWB(10): regwrite=1, regdst=0, memtoreg=0 -> FETCH.
//  BRANCH(11): alusrca=1, alusrcb=00, aluop=1011, pcsrc=01, pcwrite=zero -> FETCH.
//  JUMP(12): pcsrc=10, pcwrite=1 -> FETCH.
//  ILLOP(13): see CONFIGURATION -> FETCH.
//  Handshake: mem_req and the address/we controls stay stable until the mem_ready cycle; the access
//    completes in that same cycle. mem_ready outside FETCH/MEMRD/MEMWR is ignored.
//  Timeout: an 8-bit counter clears on state entry and increments each non-ready wait cycle.
//    When count == MEM_TIMEOUT and mem_ready=0: bus_err=1 for one cycle -> FETCH; no irwrite/pcwrite.
//    FETCH timeout retries FETCH. mem_ready in the timeout cycle wins (normal completion, no bus_err).
//  Latency: R/I/beq/j 3-4 cycles, sw 4, lw 5, plus memory wait cycles.
//  Reset mid-access: immediate return to IDLE, mem_req drops asynchronously, no writes issued.
//  Unused states 14/15 -> FETCH with all outputs 0.
// CONFIGURATION
//  MC_CTRL_ILLOP_TRAP_EN defined: ILLOP pulses exc_illop and does pcsrc=11, pcwrite=1 (load vector).
//  Not defined: ILLOP behaves as NOP; exc_illop tied 0; no PC write; -> FETCH.
// TESTING
//  Reset then release, mem_ready=1 always -> IDLE, FETCH; irwrite and pcwrite pulse in cycle 2.
//  add (op=000000), ready=1 -> states 1,2,7,8; aluop=1000 in EXEC; regwrite=1, regdst=1 in RWB.
//  lw (op=100011), ready 3 cycles late in MEMRD -> MEMRD held 4 cycles with iord=1; MEMWB memtoreg=1.
//  beq with zero=1, then zero=0 -> pcwrite=1, pcsrc=01 in BRANCH; second run pcwrite=0.
//  MEM_TIMEOUT=4, mem_ready=0 in MEMWR -> bus_err pulse after 4 wait cycles, then FETCH, mem_we never completes.
//  op=111111 with MC_CTRL_ILLOP_TRAP_EN -> exc_illop=1, pcsrc=11, pcwrite=1; without it, all 0.

Source files
------------

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control sequencer with memory req/ready handshake and timeout.
// Optional illegal-opcode trap: define MC_CTRL_ILLOP_TRAP_EN.
module mc_ctrl_fsm #(
    parameter logic [7:0] MEM_TIMEOUT = 8'd255
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       irwrite,
    output logic       pcwrite,
    output logic [1:0] pcsrc,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [3:0] aluop,
    output logic       bus_err,
    output logic       exc_illop,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        MEMADR = 4'd3,
        MEMRD  = 4'd4,
        MEMWB  = 4'd5,
        MEMWR  = 4'd6,
        EXEC   = 4'd7,
        RWB    = 4'd8,
        IEXEC  = 4'd9,
        IWB    = 4'd10,
        BRANCH = 4'd11,
        JUMP   = 4'd12,
        ILLOP  = 4'd13
    } state_t;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;

    state_t     cur;
    state_t     nxt;
    logic [7:0] cnt;
    logic       wait_st;
    logic       tmo;

    assign state   = cur;
    assign wait_st = (cur == FETCH) || (cur == MEMRD) || (cur == MEMWR);
    assign tmo     = wait_st && !mem_ready && (MEM_TIMEOUT != 8'd0)
                     && (cnt == MEM_TIMEOUT);

    // State register; async reset drops every Moore output at once.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) cur <= IDLE;
        else         cur <= nxt;
    end

    // Wait counter: cleared on any state entry (including FETCH retry).
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                  cnt <= 8'd0;
        else if (nxt != cur || tmo)   cnt <= 8'd0;
        else if (wait_st && !mem_ready) cnt <= cnt + 8'd1;
    end

    // Next-state and datapath control decode.
    always_comb begin
        nxt       = cur;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        iord      = 1'b0;
        irwrite   = 1'b0;
        pcwrite   = 1'b0;
        pcsrc     = 2'b00;
        regwrite  = 1'b0;
        regdst    = 1'b0;
        memtoreg  = 1'b0;
        alusrca   = 1'b0;
        alusrcb   = 2'b00;
        aluop     = 4'b0000;
        bus_err   = 1'b0;
        exc_illop = 1'b0;
        case (cur)
            IDLE: nxt = FETCH;
            FETCH: begin
                mem_req = 1'b1;
                alusrcb = 2'b01;
                aluop   = 4'b0100;
                if (mem_ready) begin
                    irwrite = 1'b1;
                    pcwrite = 1'b1;
                    nxt     = DECODE;
                end else if (tmo) begin
                    bus_err = 1'b1;
                    nxt     = FETCH;
                end
            end
            DECODE: begin
                alusrcb = 2'b11;
                aluop   = 4'b0100;
                if (op == OP_R)                      nxt = EXEC;
                else if (op == OP_LW || op == OP_SW) nxt = MEMADR;
                else if (op == OP_BEQ)               nxt = BRANCH;
                else if (op == OP_J)                 nxt = JUMP;
                else if (op[5:3] == 3'b001)          nxt = IEXEC;
                else                                 nxt = ILLOP;
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                aluop   = 4'b0100;
                nxt     = (op == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) nxt = MEMWB;
                else if (tmo) begin
                    bus_err = 1'b1;
                    nxt     = FETCH;
                end
            end
            MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
                nxt      = FETCH;
            end
            MEMWR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
                if (mem_ready) nxt = FETCH;
                else if (tmo) begin
                    bus_err = 1'b1;
                    nxt     = FETCH;
                end
            end
            EXEC: begin
                alusrca = 1'b1;
                aluop   = 4'b1000;
                nxt     = RWB;
            end
            RWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
                nxt      = FETCH;
            end
            IEXEC: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                case (op[2:0])
                    3'b000:  aluop = 4'b0100;
                    3'b001:  aluop = 4'b0101;
                    3'b010:  aluop = 4'b0110;
                    3'b011:  aluop = 4'b0111;
                    3'b100:  aluop = 4'b0000;
                    3'b101:  aluop = 4'b0011;
                    3'b110:  aluop = 4'b0001;
                    default: aluop = 4'b0010;
                endcase
                nxt = IWB;
            end
            IWB: begin
                regwrite = 1'b1;
                nxt      = FETCH;
            end
            BRANCH: begin
                alusrca = 1'b1;
                aluop   = 4'b1011;
                pcsrc   = 2'b01;
                pcwrite = zero;
                nxt     = FETCH;
            end
            JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
                nxt     = FETCH;
            end
            ILLOP: begin
`ifdef MC_CTRL_ILLOP_TRAP_EN
                exc_illop = 1'b1;
                pcsrc     = 2'b11;
                pcwrite   = 1'b1;
`endif
                nxt = FETCH;
            end
            default: nxt = FETCH;
        endcase
    end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: per-cycle expected control vectors.
// Built with MEM_TIMEOUT=4 so timeout paths are reachable.
module tb_mc_ctrl_fsm;

    typedef struct packed {
        logic [3:0] st;
        logic       req;
        logic       we;
        logic       iord;
        logic       irw;
        logic       pcw;
        logic [1:0] pcsrc;
        logic       rw;
        logic       rd;
        logic       m2r;
        logic       asa;
        logic [1:0] asb;
        logic [3:0] aop;
        logic       berr;
        logic       ill;
    } vec_t;

    logic       clk = 1'b0;
    logic       resetn;
    logic [5:0] op;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, mem_we, iord, irwrite, pcwrite;
    logic [1:0] pcsrc;
    logic       regwrite, regdst, memtoreg, alusrca;
    logic [1:0] alusrcb;
    logic [3:0] aluop;
    logic       bus_err, exc_illop;
    logic [3:0] state;

    int   n_chk = 0;
    int   n_err = 0;
    int   n_cyc = 0;
    vec_t sb_q[$];

    logic [5:0] iops [8] = '{6'h08, 6'h09, 6'h0a, 6'h0b,
                             6'h0c, 6'h0d, 6'h0e, 6'h0f};
    logic [3:0] iaop [8] = '{4'b0100, 4'b0101, 4'b0110, 4'b0111,
                             4'b0000, 4'b0011, 4'b0001, 4'b0010};

    always #5 clk = ~clk;

    mc_ctrl_fsm #(.MEM_TIMEOUT(8'd4)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .op        (op),
        .zero      (zero),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .iord      (iord),
        .irwrite   (irwrite),
        .pcwrite   (pcwrite),
        .pcsrc     (pcsrc),
        .regwrite  (regwrite),
        .regdst    (regdst),
        .memtoreg  (memtoreg),
        .alusrca   (alusrca),
        .alusrcb   (alusrcb),
        .aluop     (aluop),
        .bus_err   (bus_err),
        .exc_illop (exc_illop),
        .state     (state)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, want);
        end
    endtask

    // Expected control vector for one cycle in state s.
    function automatic vec_t ex(input int s, input bit rdy, input bit z,
                                input bit be);
        vec_t v = '0;
        v.st = s[3:0];
        case (s)
            1: begin
                v.req = 1; v.asb = 2'b01; v.aop = 4'b0100;
                v.irw = rdy; v.pcw = rdy;
            end
            2: begin v.asb = 2'b11; v.aop = 4'b0100; end
            3: begin v.asa = 1; v.asb = 2'b10; v.aop = 4'b0100; end
            4: begin v.req = 1; v.iord = 1; end
            5: begin v.rw = 1; v.m2r = 1; end
            6: begin v.req = 1; v.we = 1; v.iord = 1; end
            7: begin v.asa = 1; v.aop = 4'b1000; end
            8: begin v.rw = 1; v.rd = 1; end
            9: begin v.asa = 1; v.asb = 2'b10; v.aop = iaop[op[2:0]]; end
            10: v.rw = 1;
            11: begin
                v.asa = 1; v.aop = 4'b1011; v.pcsrc = 2'b01; v.pcw = z;
            end
            12: begin v.pcsrc = 2'b10; v.pcw = 1; end
            13: begin
`ifdef MC_CTRL_ILLOP_TRAP_EN
                v.ill = 1; v.pcsrc = 2'b11; v.pcw = 1;
`endif
            end
            default: ;
        endcase
        v.berr = be;
        return v;
    endfunction

    task automatic cyc(input int s, input bit rdy = 1'b0,
                       input bit z = 1'b0, input bit be = 1'b0);
        mem_ready = rdy;
        zero      = z;
        sb_q.push_back(ex(s, rdy, z, be));
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare DUT outputs against the scoreboard mid-cycle.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            vec_t w;
            vec_t g;
            w = sb_q.pop_front();
            g = {state, mem_req, mem_we, iord, irwrite, pcwrite, pcsrc,
                 regwrite, regdst, memtoreg, alusrca, alusrcb, aluop,
                 bus_err, exc_illop};
            check($sformatf("cyc%0d_st%0d", n_cyc, w.st),
                  32'(g), 32'(w));
            n_cyc++;
        end
    end

    initial begin
        resetn = 1'b1; op = '0; zero = 1'b0; mem_ready = 1'b0;
        #2 resetn = 1'b0;
        @(posedge clk); #1;
        // held in reset, ready asserted must not matter
        cyc(0, 1); cyc(0, 1);
        resetn = 1'b1;
        // add
        op = 6'b000000;
        cyc(0, 1); cyc(1, 1); cyc(2, 1); cyc(7, 1); cyc(8, 1);
        // lw, ready 3 cycles late
        op = 6'b100011;
        cyc(1, 1); cyc(2); cyc(3);
        cyc(4, 0); cyc(4, 0); cyc(4, 0); cyc(4, 1); cyc(5);
        // beq taken / not taken
        op = 6'b000100;
        cyc(1, 1); cyc(2); cyc(11, 0, 1);
        cyc(1, 1); cyc(2); cyc(11, 0, 0);
        // j
        op = 6'b000010;
        cyc(1, 1); cyc(2); cyc(12);
        // all I-type ops
        for (int i = 0; i < 8; i++) begin
            op = iops[i];
            cyc(1, 1); cyc(2); cyc(9); cyc(10);
        end
        // sw never ready: 4 wait cycles then bus_err
        op = 6'b101011;
        cyc(1, 1); cyc(2); cyc(3);
        cyc(6); cyc(6); cyc(6); cyc(6); cyc(6, 0, 0, 1);
        // fetch timeout then retry
        op = 6'b000000;
        cyc(1); cyc(1); cyc(1); cyc(1); cyc(1, 0, 0, 1);
        cyc(1, 1); cyc(2); cyc(7); cyc(8);
        // lw: ready in the timeout cycle wins
        op = 6'b100011;
        cyc(1, 1); cyc(2); cyc(3);
        cyc(4); cyc(4); cyc(4); cyc(4); cyc(4, 1); cyc(5);
        // illegal opcode
        op = 6'b111111;
        cyc(1, 1); cyc(2); cyc(13);
        // sw normal
        op = 6'b101011;
        cyc(1, 1); cyc(2); cyc(3); cyc(6, 1);
        // sw with reset mid-access
        cyc(1, 1); cyc(2); cyc(3); cyc(6);
        resetn = 1'b0;
        cyc(0);
        resetn = 1'b1;
        cyc(0); cyc(1, 1);
        @(negedge clk); #1;
        check("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
